// File: rtl/sort_result_checker.sv
// Consumer-side checker for the bubble-sort datapath: loads a reference frame into
// a per-value histogram, then verifies the result stream is ordered and a permutation.
module sort_result_checker #(
  parameter int unsigned W  = 3,
  parameter int unsigned N  = 8,
  parameter int unsigned CW = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ref_valid,
  input  logic [W-1:0] ref_data,
  output logic         ref_ready,
  input  logic         res_valid,
  input  logic [W-1:0] res_data,
  output logic         res_ready,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic         err_order,
  output logic         err_perm
);

  localparam int unsigned NB = 1 << W;

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, REPORT} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] hist_q [NB];
  logic [CW-1:0] hist_d [NB];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  prev_q, prev_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic          eo_q, eo_d;
  logic          ep_q, ep_d;
  logic          ref_fire, res_fire;

  // Handshake readiness depends only on the current state.
  assign ref_ready = (state_q == IDLE) || (state_q == LOAD);
  assign res_ready = (state_q == CHECK);
  assign ref_fire  = ref_valid && ref_ready;
  assign res_fire  = res_valid && res_ready;

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    cnt_d   = cnt_q;
    prev_d  = prev_q;
    pass_d  = pass_q;
    eo_d    = eo_q;
    ep_d    = ep_q;
    case (state_q)
      IDLE: begin
        if (ref_fire) begin
          hist_d[ref_data] = hist_q[ref_data] + CW'(1);
          pass_d = 1'b0;
          eo_d   = 1'b0;
          ep_d   = 1'b0;
          if (N == 1) begin
            state_d = CHECK;
            cnt_d   = '0;
          end else begin
            state_d = LOAD;
            cnt_d   = CW'(1);
          end
        end
      end
      LOAD: begin
        if (ref_fire) begin
          hist_d[ref_data] = hist_q[ref_data] + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            state_d = CHECK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      CHECK: begin
        if (res_fire) begin
          // An exhausted bin means the result holds a value the reference lacked.
          if (hist_q[res_data] == '0) begin
            ep_d = 1'b1;
          end else begin
            hist_d[res_data] = hist_q[res_data] - CW'(1);
          end
          if ((cnt_q != '0) && (res_data < prev_q)) begin
            eo_d = 1'b1;
          end
          prev_d = res_data;
          if (cnt_q == CW'(N - 1)) begin
            state_d = REPORT;
            cnt_d   = '0;
            pass_d  = !eo_d && !ep_d;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      REPORT: begin
        hist_d  = '{default: '0};
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are registered copies of the decoded next state.
  always_comb begin
    busy_d = (state_d == LOAD) || (state_d == CHECK);
    done_d = (state_d == REPORT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hist_q  <= '{default: '0};
      cnt_q   <= '0;
      prev_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      eo_q    <= 1'b0;
      ep_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      eo_q    <= eo_d;
      ep_q    <= ep_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_order = eo_q;
  assign err_perm  = ep_q;

endmodule

// File: tb/tb_sort_result_checker.sv
// Bench for sort_result_checker: directed and random frames, expected verdicts
// derived from sortedness and multiset comparison of whole frames.
module tb_sort_result_checker;

  localparam int W  = 3;
  localparam int N  = 8;
  localparam int CW = 4;
  localparam int NB = 1 << W;
  localparam int IW = $clog2(N);

  typedef logic [W-1:0] frame_t [N];

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ref_valid = 1'b0;
  logic [W-1:0] ref_data = '0;
  logic         ref_ready;
  logic         res_valid = 1'b0;
  logic [W-1:0] res_data = '0;
  logic         res_ready;
  logic         busy, done, pass, err_order, err_perm;

  int checks = 0;
  int errors = 0;

  sort_result_checker #(.W(W), .N(N), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ref_valid (ref_valid),
    .ref_data  (ref_data),
    .ref_ready (ref_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_ready (res_ready),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_order (err_order),
    .err_perm  (err_perm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Verdict from frame-level properties: any descending step, any multiset difference.
  function automatic void model(input frame_t r, input frame_t s, output bit eo, output bit ep);
    int cr [NB];
    int cs [NB];
    for (int k = 0; k < NB; k++) begin
      cr[k] = 0;
      cs[k] = 0;
    end
    eo = 1'b0;
    ep = 1'b0;
    for (int i = 0; i < N; i++) begin
      cr[r[IW'(i)]]++;
      cs[s[IW'(i)]]++;
      if (i > 0 && s[IW'(i)] < s[IW'(i - 1)]) eo = 1'b1;
    end
    for (int k = 0; k < NB; k++) if (cr[k] != cs[k]) ep = 1'b1;
  endfunction

  function automatic void sort_frame(input frame_t r, output frame_t s);
    int idx = 0;
    for (int v = 0; v < NB; v++)
      for (int i = 0; i < N; i++)
        if (int'(r[IW'(i)]) == v) begin
          s[IW'(idx)] = r[IW'(i)];
          idx++;
        end
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'd0);
    check({tag, "_eo"}, 32'(err_order), 32'd0);
    check({tag, "_ep"}, 32'(err_perm), 32'd0);
    check({tag, "_ref_ready"}, 32'(ref_ready), 32'd1);
    check({tag, "_res_ready"}, 32'(res_ready), 32'd0);
  endtask

  // Runs one frame starting at a negedge; abort_after >= 0 resets after that many results.
  task automatic run_frame(input string tag, input frame_t r, input frame_t s,
                           input bit gaps, input bit junk, input int abort_after);
    bit eo, ep, acc;
    int i, guard;
    model(r, s, eo, ep);
    i = 0;
    guard = 0;
    while (i < N && guard < 1000) begin
      guard++;
      res_valid = junk;
      res_data  = W'($urandom);
      if (gaps && $urandom_range(0, 2) == 0) ref_valid = 1'b0;
      else begin
        ref_valid = 1'b1;
        ref_data  = r[IW'(i)];
      end
      if (junk) check({tag, "_junk_res_ready"}, 32'(res_ready), 32'd0);
      acc = ref_valid && ref_ready;
      @(posedge clk);
      if (acc) i++;
      @(negedge clk);
      if (acc && i == 1) begin
        check({tag, "_clr_pass"}, 32'(pass), 32'd0);
        check({tag, "_clr_eo"}, 32'(err_order), 32'd0);
        check({tag, "_clr_ep"}, 32'(err_perm), 32'd0);
        check({tag, "_busy_load"}, 32'(busy), 32'd1);
      end
    end
    if (i < N) check({tag, "_ref_timeout"}, 32'(i), 32'(N));
    ref_valid = 1'b0;
    res_valid = 1'b0;
    i = 0;
    guard = 0;
    while (i < N && guard < 1000) begin
      guard++;
      ref_valid = junk;
      ref_data  = W'($urandom);
      if (gaps && $urandom_range(0, 2) == 0) res_valid = 1'b0;
      else begin
        res_valid = 1'b1;
        res_data  = s[IW'(i)];
      end
      acc = res_valid && res_ready;
      @(posedge clk);
      if (acc) i++;
      @(negedge clk);
      ref_valid = 1'b0;
      res_valid = 1'b0;
      if (i == abort_after) begin
        rst_n = 1'b0;
        #1;
        check_reset_state({tag, "_midreset"});
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      check({tag, "_done_timing"}, 32'(done), 32'(i == N));
    end
    if (i < N) check({tag, "_res_timeout"}, 32'(i), 32'(N));
    check({tag, "_pass"}, 32'(pass), 32'(!eo && !ep));
    check({tag, "_eo"}, 32'(err_order), 32'(eo));
    check({tag, "_ep"}, 32'(err_perm), 32'(ep));
    check({tag, "_busy_report"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_pass_held"}, 32'(pass), 32'(!eo && !ep));
    check({tag, "_idle_ref_ready"}, 32'(ref_ready), 32'd1);
  endtask

  initial begin
    frame_t ra, sa, sb, rc, sc, rr, sr;
    ra = '{3'd5, 3'd3, 3'd7, 3'd0, 3'd1, 3'd6, 3'd2, 3'd4};
    sa = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    sb = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd3, 3'd5, 3'd6, 3'd7};
    rc = '{3'd2, 3'd2, 3'd0, 3'd1, 3'd5, 3'd6, 3'd7, 3'd7};
    sc = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7, 3'd7};

    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_frame("t1_sorted", ra, sa, 1'b0, 1'b0, -1);
    run_frame("t2_order", ra, sb, 1'b0, 1'b0, -1);
    run_frame("t3_perm", rc, sc, 1'b0, 1'b0, -1);
    run_frame("t4_gaps_junk", ra, sa, 1'b1, 1'b1, -1);
    run_frame("t5_abort", ra, sa, 1'b0, 1'b0, 4);
    run_frame("t5_clean", ra, sa, 1'b0, 1'b0, -1);
    run_frame("t6_first", ra, sb, 1'b0, 1'b0, -1);
    run_frame("t6_second", ra, sa, 1'b0, 1'b0, -1);

    for (int t = 0; t < 12; t++) begin
      int a, b;
      logic [W-1:0] tmp;
      for (int i = 0; i < N; i++) rr[IW'(i)] = W'($urandom);
      sort_frame(rr, sr);
      a = int'($urandom_range(0, N - 1));
      b = int'($urandom_range(0, N - 1));
      case ($urandom_range(0, 2))
        1: begin
          tmp = sr[IW'(a)];
          sr[IW'(a)] = sr[IW'(b)];
          sr[IW'(b)] = tmp;
        end
        2: sr[IW'(a)] = W'($urandom);
        default: ;
      endcase
      run_frame("rand", rr, sr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
